inst_prefetch_queue: RTL
========================

# inst_prefetch_queue

Instruction prefetch stage between the instruction memory port and the `fetch` stage of the pipelined RISC-V core. It owns the sequential fetch PC and issues one word request at a time to instruction memory. Returned words are buffered, each tagged with its PC, in a small FIFO that `fetch` drains under a valid/ready handshake. On a branch or jump redirect it flushes all queued and in-flight instructions and restarts at the target PC.

## Interface
- `DEPTH`, 4: FIFO entries; power of two, 2..16.
- `RESET_PC`, 32'h0000_0000: first fetch address after reset.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `mem_req` out 1: single-cycle request pulse; memory always accepts it.
- `mem_addr` out 32: word address of the request; bits [1:0] are always 0.
- `mem_rvalid` in 1: response valid; arrives ≥1 cycle after `mem_req`.
- `mem_rdata` in 32: instruction word, sampled when `mem_rvalid`=1.
- `inst_valid` out 1: queue head is valid.
- `inst_data` out 32: head instruction; 0 when `inst_valid`=0.
- `inst_pc` out 32: head PC; 0 when `inst_valid`=0.
- `inst_ready` in 1: `fetch` consumes the head this cycle (low = stall).
- `redirect` in 1: flush request (taken branch or jump, from `memory`).
- `redirect_pc` in 32: new fetch PC; bits [1:0] are forced to 0.

## Operation
- State registers: `state` ∈ {S_ISSUE, S_WAIT, S_DROP}, `fetch_pc`, `req_pc` (PC of the outstanding request), FIFO `count` and read/write pointers.
- At most one outstanding memory request, so `count` + outstanding ≤ DEPTH always holds.
- `mem_req` = (state==S_ISSUE) && (count<DEPTH) && !redirect && !rst. This is combinational.
- When `mem_req`=1, `mem_addr`=`fetch_pc`. Next cycle: `req_pc`←`fetch_pc`, `fetch_pc`←`fetch_pc`+4 (wraps modulo 2^32), state → S_WAIT.
- S_WAIT with `mem_rvalid`=1 and no redirect: push {`req_pc`, `mem_rdata`} and go to S_ISSUE.
- S_WAIT with `redirect` and no `mem_rvalid`: go to S_DROP.
- S_WAIT with `redirect` and `mem_rvalid` in the same cycle: discard the data and go to S_ISSUE.
- S_DROP with `mem_rvalid`=1: discard the data and go to S_ISSUE. A redirect in S_DROP only updates `fetch_pc`; the state stays S_DROP.
- `redirect` in any state: `fetch_pc`←{`redirect_pc`[31:2],2'b00}, FIFO emptied (count=0, pointers=0).
- Redirect priority: `redirect` overrides a push and a pop in the same cycle. The popped head is considered squashed.
- Pop happens when `inst_valid` && `inst_ready`. `inst_valid` = (count≠0).
- Simultaneous push and pop: `count` is unchanged and both pointers advance (pointers wrap modulo DEPTH).
- S_ISSUE with count==DEPTH: no request; the block waits for a pop.
- `mem_rvalid` in S_ISSUE is a protocol violation and is ignored. Add an assertion for it in simulation.

## Timing
- Reset values: `mem_req`=0, `inst_valid`=0, `inst_data`=0, `inst_pc`=0, state=S_ISSUE, `fetch_pc`=RESET_PC, count=0.
- The first `mem_req` occurs in the first cycle with `rst`=0.
- Latency: `mem_rvalid` in cycle N gives `inst_valid`=1 at cycle N+1 if the queue was empty.
- Peak throughput with 1-cycle memory is one instruction per 2 cycles: request in cycle N, response in N+1, next request in N+2.
- Redirect in cycle N:
  - `inst_valid`=0 at N+1.
  - The earliest new request, from S_ISSUE, is at N+1 with `mem_addr`=`redirect_pc`.
  - From S_DROP, the new request comes one cycle after the stale `mem_rvalid`.
- Reset mid-operation: the outstanding response is not tracked after reset. Memory must be reset together with this block.

## Structure
- Shared package `cpu_pkg`: `XLEN`=32, `fetch_state_t` enum, `NOP_INSN`=32'h0000_0013, and the packed struct `fetch_entry_t` {pc, insn}.
- One sub-module, `sync_fifo` (parameterised width and depth, push/pop/flush, count output), holds `fetch_entry_t`. It is reusable for later store buffers.
- The FSM and PC logic live in `inst_prefetch_queue`.

## Test plan
- Reset with RESET_PC=32'h100 and 1-cycle memory: `mem_req` occurs in the first cycle after `rst` falls with `mem_addr`=32'h100. `inst_pc` then takes 32'h100, 32'h104, 32'h108, … at one instruction per 2 cycles.
- Hold `inst_ready`=0 with DEPTH=4: exactly 4 requests issue, then `mem_req` stays 0. Raising `inst_ready` drains 32'h100–32'h10C in order, then fetch resumes at 32'h110.
- Memory latency 3; assert `redirect` to 32'h2002 while in S_WAIT: the stale word is dropped and never appears. The next `mem_addr`=32'h2000, issued the cycle after the stale `mem_rvalid`.
- `redirect` in the same cycle as `mem_rvalid` and a pop: nothing is pushed, the queue is empty next cycle, and `mem_addr`=`redirect_pc` in that next cycle.
- Two back-to-back redirects (32'h400, then 32'h800) while in S_DROP: only 32'h800 is fetched, and 32'h400 is never requested.
- `fetch_pc`=32'hFFFF_FFFC: the next request address wraps to 32'h0000_0000.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared core types: machine width, prefetch FSM states, buffered fetch entry.
package cpu_pkg;

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSN = 32'h0000_0013;

  typedef enum logic [1:0] {
    S_ISSUE = 2'd0,
    S_WAIT  = 2'd1,
    S_DROP  = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] insn;
  } fetch_entry_t;

  // Clear the byte-offset bits so an address points at a whole word.
  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/inst_prefetch_queue_if.sv
// Memory-side and fetch-side signals of the prefetch queue.
// The prefetch block sits on the slave side; the surrounding core/memory is master.
interface inst_prefetch_queue_if;
  import cpu_pkg::*;

  logic            mem_req;
  logic [XLEN-1:0] mem_addr;
  logic            mem_rvalid;
  logic [XLEN-1:0] mem_rdata;
  logic            inst_valid;
  logic [XLEN-1:0] inst_data;
  logic [XLEN-1:0] inst_pc;
  logic            inst_ready;
  logic            redirect;
  logic [XLEN-1:0] redirect_pc;

  modport slave (
    output mem_req, mem_addr, inst_valid, inst_data, inst_pc,
    input  mem_rvalid, mem_rdata, inst_ready, redirect, redirect_pc
  );

  modport master (
    input  mem_req, mem_addr, inst_valid, inst_data, inst_pc,
    output mem_rvalid, mem_rdata, inst_ready, redirect, redirect_pc
  );

endinterface

// File: rtl/inst_prefetch_queue_chk.sv
// Simulation checks on the prefetch queue: memory must not answer when no
// request is outstanding, and buffered plus in-flight words fit the queue.
module inst_prefetch_queue_chk
  import cpu_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CW    = 3
) (
  input logic         clk,
  input logic         rst,
  input fetch_state_t state,
  input logic         mem_rvalid,
  input logic [CW-1:0] count
);

  logic outstanding;
  assign outstanding = (state != S_ISSUE);

  // A response while idle means the memory broke the one-request protocol.
  a_no_stray_rvalid: assert property (@(posedge clk) disable iff (rst)
    !((state == S_ISSUE) && mem_rvalid))
    else $error("prefetch protocol: mem_rvalid with no request outstanding");

  // The single outstanding request always has a free slot reserved for it.
  a_capacity: assert property (@(posedge clk) disable iff (rst)
    ({1'b0, count} + {{CW{1'b0}}, outstanding}) <= (CW + 1)'(DEPTH))
    else $error("prefetch capacity exceeded");

endmodule

// File: rtl/sync_fifo.sv
// Generic synchronous FIFO with flush. Push and pop may coincide, including
// when full; flush wins over both. DEPTH must be a power of two so the
// pointers wrap naturally.
module sync_fifo #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic [CW-1:0]    count,
  output logic             empty,
  output logic             full
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign empty   = (count == {CW{1'b0}});
  assign full    = (count == CW'(DEPTH));
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);
  assign rdata   = mem[rd_ptr];

  // Store the incoming word; storage needs no reset, count qualifies it.
  always_ff @(posedge clk) begin
    if (push_ok && !flush) begin
      mem[wr_ptr] <= wdata;
    end else begin
      mem[wr_ptr] <= mem[wr_ptr];
    end
  end

  // Pointer and occupancy bookkeeping; flush empties the queue outright.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr <= {AW{1'b0}};
      wr_ptr <= {AW{1'b0}};
      count  <= {CW{1'b0}};
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + AW'(1);
      end else begin
        wr_ptr <= wr_ptr;
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + AW'(1);
      end else begin
        rd_ptr <= rd_ptr;
      end
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/inst_prefetch_queue.sv
// Instruction prefetch stage: owns the sequential fetch PC, keeps one word
// request in flight, buffers returned words tagged with their PC, and flushes
// everything (including an in-flight word) on a redirect.
module inst_prefetch_queue
  import cpu_pkg::*;
#(
  parameter int unsigned     DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input logic                  clk,
  input logic                  rst,
  inst_prefetch_queue_if.slave bus
);

  localparam int unsigned CW = $clog2(DEPTH + 1);

  fetch_state_t    state;
  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] req_pc;
  logic [CW-1:0]   count;
  logic            empty;
  logic            full;
  logic            push;
  logic            pop;
  fetch_entry_t    wentry;
  fetch_entry_t    rentry;
  logic            unused_pc_bits;

  // Redirect targets are word-aligned here, so their low bits are ignored.
  assign unused_pc_bits = ^bus.redirect_pc[1:0];

  // A new request only when idle, with room reserved, and not being flushed.
  assign bus.mem_req  = (state == S_ISSUE) && !full && !bus.redirect && !rst;
  assign bus.mem_addr = fetch_pc;

  // Redirect squashes both the arriving word and the head being consumed.
  assign push = (state == S_WAIT) && bus.mem_rvalid && !bus.redirect;
  assign pop  = !empty && bus.inst_ready && !bus.redirect;

  assign wentry.pc   = req_pc;
  assign wentry.insn = bus.mem_rdata;

  assign bus.inst_valid = !empty;
  assign bus.inst_data  = empty ? {XLEN{1'b0}} : rentry.insn;
  assign bus.inst_pc    = empty ? {XLEN{1'b0}} : rentry.pc;

  sync_fifo #(
    .WIDTH($bits(fetch_entry_t)),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (bus.redirect),
    .push  (push),
    .wdata (wentry),
    .pop   (pop),
    .rdata (rentry),
    .count (count),
    .empty (empty),
    .full  (full)
  );

  // Request FSM and PC tracking; S_DROP waits out a word that a redirect killed.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_ISSUE;
      fetch_pc <= word_align(RESET_PC);
      req_pc   <= {XLEN{1'b0}};
    end else begin
      case (state)
        S_ISSUE: begin
          if (bus.mem_req) begin
            state  <= S_WAIT;
            req_pc <= fetch_pc;
          end else begin
            state  <= S_ISSUE;
            req_pc <= req_pc;
          end
        end
        S_WAIT: begin
          req_pc <= req_pc;
          if (bus.mem_rvalid) begin
            state <= S_ISSUE;
          end else if (bus.redirect) begin
            state <= S_DROP;
          end else begin
            state <= S_WAIT;
          end
        end
        S_DROP: begin
          req_pc <= req_pc;
          if (bus.mem_rvalid) begin
            state <= S_ISSUE;
          end else begin
            state <= S_DROP;
          end
        end
        default: begin
          state  <= S_ISSUE;
          req_pc <= req_pc;
        end
      endcase

      if (bus.redirect) begin
        fetch_pc <= word_align(bus.redirect_pc);
      end else if (bus.mem_req) begin
        fetch_pc <= fetch_pc + 32'd4;
      end else begin
        fetch_pc <= fetch_pc;
      end
    end
  end

  inst_prefetch_queue_chk #(
    .DEPTH(DEPTH),
    .CW   (CW)
  ) u_chk (
    .clk        (clk),
    .rst        (rst),
    .state      (state),
    .mem_rvalid (bus.mem_rvalid),
    .count      (count)
  );

endmodule
